// File: rtl/fifo_arb_pkg.sv
// Shared types and limits for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int MAX_NUM_REQ = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req after last_owner_i, wrapping around.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDXW-1:0]    last_owner_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               valid_o
);

  // Two ascending passes: indices above last_owner first, then the wrapped range.
  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid_o && req_i[i] && (i > int'(last_owner_i))) begin
        pick_o[i] = 1'b1;
        valid_o   = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid_o && req_i[i] && (i <= int'(last_owner_i))) begin
        pick_o[i] = 1'b1;
        valid_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for a shared FIFO write port; registered write, combinational ack.
// Optional FIFO_ARB_TIMEOUT_EN caps each grant at MAX_BURST words.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full
);

  localparam int IDXW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_cfg
    $error("fifo_wr_arbiter: parameter out of range");
  end

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [IDXW-1:0]       owner_q, owner_d;
  logic [IDXW-1:0]       last_owner_q, last_owner_d;
  logic                  fifo_wr_q, fifo_wr_d;
  logic [DATA_WIDTH-1:0] fifo_w_data_q, fifo_w_data_d;
  logic [NUM_REQ-1:0]    pick;
  logic                  pick_vld;
  logic [IDXW-1:0]       pick_idx;
  logic                  accept;
  logic                  burst_end;
`ifdef FIFO_ARB_TIMEOUT_EN
  logic [7:0]            burst_cnt_q, burst_cnt_d;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_rr_pick (
    .req_i        (req),
    .last_owner_i (last_owner_q),
    .pick_o       (pick),
    .valid_o      (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IDXW'(i);
    end
  end

  // A write already in flight consumes the last free slot, so almost-full must stall too.
  assign accept = !fifo_full && !(fifo_almost_full && fifo_wr_q);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    fifo_wr_d     = 1'b0;
    fifo_w_data_d = fifo_w_data_q;
    ack           = '0;
    burst_end     = 1'b0;
`ifdef FIFO_ARB_TIMEOUT_EN
    burst_cnt_d   = burst_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BURST;
          grant_d = pick;
          owner_d = pick_idx;
`ifdef FIFO_ARB_TIMEOUT_EN
          burst_cnt_d = '0;
`endif
        end
      end
      BURST: begin
        if (req[owner_q] && accept) begin
          ack[owner_q]  = 1'b1;
          fifo_wr_d     = 1'b1;
          fifo_w_data_d = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
          burst_end     = req_last[owner_q];
`ifdef FIFO_ARB_TIMEOUT_EN
          burst_cnt_d   = burst_cnt_q + 8'd1;
          if (burst_cnt_d == 8'(MAX_BURST)) burst_end = 1'b1;
`endif
          if (burst_end) begin
            state_d      = IDLE;
            grant_d      = '0;
            last_owner_d = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      last_owner_q  <= IDXW'(NUM_REQ - 1);
      fifo_wr_q     <= 1'b0;
      fifo_w_data_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_w_data_q <= fifo_w_data_d;
    end
  end

`ifdef FIFO_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) burst_cnt_q <= '0;
    else       burst_cnt_q <= burst_cnt_d;
  end
`endif

  assign grant       = grant_q;
  assign fifo_wr     = fifo_wr_q;
  assign fifo_w_data = fifo_w_data_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester queues, a depth-16 FIFO model and a write scoreboard.
module tb_fifo_wr_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     req_last = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     ack, grant;
  logic              fifo_wr;
  logic [DW-1:0]     fifo_w_data;
  logic              fifo_full, fifo_almost_full;

  logic [NR-1:0]     hold = '0;
  logic              fifo_hold = 1'b0;
  int                fcnt = 0;
  int                ovf = 0;
  int                wr_cnt = 0;
  int                af_hits = 0;
  int                checks = 0;
  int                errors = 0;
  logic [DW:0]       rq [NR][$];
  logic [DW-1:0]     sb [$];
  int                glog [$];
  logic [NR-1:0]     ack_s = '0;
  logic [NR-1:0]     prev_grant = '0;
  logic              prev_ack = 1'b0;

  always #5 clk = ~clk;

  assign fifo_full        = (fcnt == DEPTH);
  assign fifo_almost_full = (fcnt >= DEPTH - 1);

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .req_data         (req_data),
    .req_last         (req_last),
    .ack              (ack),
    .grant            (grant),
    .fifo_wr          (fifo_wr),
    .fifo_w_data      (fifo_w_data),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int oh2idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int glog_at(input int i);
    if (glog.size() > i) return glog[i];
    return -1;
  endfunction

  // FIFO model: drains instantly unless fifo_hold is set.
  always @(posedge clk) begin
    if (!fifo_hold) fcnt <= 0;
    else if (fifo_wr && !reset) begin
      if (fcnt >= DEPTH) ovf <= ovf + 1;
      else fcnt <= fcnt + 1;
    end
  end

  // Requester model: pop the word acked last cycle, present the next queue head.
  always @(posedge clk) begin
    logic [DW:0] w;
    #1;
    for (int i = 0; i < NR; i++) begin
      if (ack_s[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (rq[i].size() > 0 && !hold[i]) begin
        w = rq[i][0];
        req[i] = 1'b1;
        req_data[i*DW +: DW] = w[DW-1:0];
        req_last[i] = w[DW];
      end else begin
        req[i] = 1'b0;
        req_last[i] = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pops on writes, protocol checks, grant log.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    ack_s = ack;
    if (reset) begin
      prev_ack = 1'b0;
      prev_grant = '0;
    end else begin
      chk("wr_follows_ack", 32'(fifo_wr), 32'(prev_ack));
      if (fifo_wr) begin
        wr_cnt++;
        chk("no_wr_when_full", 32'(fifo_full), 0);
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("wdata", 32'(fifo_w_data), 32'(e));
        end
      end
      if (fifo_almost_full && fifo_wr) af_hits++;
      if (fifo_full || (fifo_almost_full && fifo_wr)) chk("ack_blocked", 32'(ack), 0);
      chk("ack_within_grant", 32'((ack & ~grant) != 0), 0);
      if (grant != 0 && grant != prev_grant) glog.push_back(oh2idx(grant));
      prev_grant = grant;
      prev_ack = |ack;
    end
  end

  task automatic push_word(input int r, input int d, input bit last);
    rq[r].push_back({last, DW'(d)});
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1;
    hold = '0;
    fifo_hold = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NR; i++) rq[i].delete();
    sb.delete();
    @(negedge clk); #1;
    reset = 1'b0;
    glog.delete();
    wr_cnt = 0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while (n < maxc && !(all_empty() && grant == 0 && !fifo_wr && sb.size() == 0)) begin
      @(negedge clk); #2;
      n++;
    end
    chk(tag, 32'(n < maxc), 1);
  endtask

  task automatic wait_grant(input string tag, input int idx, input int maxc);
    int n = 0;
    while (n < maxc && grant !== NR'(1 << idx)) begin
      @(negedge clk); #2;
      n++;
    end
    chk(tag, 32'(n < maxc), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_fifo_wr", 32'(fifo_wr), 0);
    chk("rst_wdata", 32'(fifo_w_data), 0);
    chk("rst_ack", 32'(ack), 0);
    reset = 1'b0;
    glog.delete();
    wr_cnt = 0;

    // Requesters 1 and 2, three-word bursts each
    for (int k = 0; k < 3; k++) begin
      push_word(1, 1 + k, k == 2);
      push_word(2, 4 + k, k == 2);
    end
    for (int k = 1; k <= 6; k++) sb.push_back(DW'(k));
    wait_done("t1_done", 60);
    chk("t1_ngrants", glog.size(), 2);
    chk("t1_first", glog_at(0), 1);
    chk("t1_second", glog_at(1), 2);
    chk("t1_writes", wr_cnt, 6);

    // All four requesters, single-word bursts, two rounds
    do_reset();
    for (int rnd = 0; rnd < 2; rnd++)
      for (int r = 0; r < NR; r++) begin
        push_word(r, rnd * 4 + r, 1'b1);
        sb.push_back(DW'(rnd * 4 + r));
      end
    wait_done("t2_done", 80);
    chk("t2_ngrants", glog.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_order", glog_at(i), i % NR);
    chk("t2_writes", wr_cnt, 8);

    // Owner drops req mid-burst while requester 2 waits
    glog.delete();
    for (int k = 0; k < 3; k++) push_word(1, 9 + k, k == 2);
    wait_grant("t3_grant1", 1, 20);
    hold[1] = 1'b1;
    push_word(2, 12, 1'b0);
    push_word(2, 13, 1'b1);
    for (int k = 9; k <= 13; k++) sb.push_back(DW'(k));
    repeat (3) begin
      @(negedge clk); #2;
      chk("t3_hold_grant", 32'(grant), 32'(4'b0010));
      chk("t3_hold_ack", 32'(ack), 0);
    end
    hold[1] = 1'b0;
    wait_done("t3_done", 60);
    chk("t3_ngrants", glog.size(), 2);
    chk("t3_first", glog_at(0), 1);
    chk("t3_second", glog_at(1), 2);

    // Requester 0 streams 20 words into a 16-deep FIFO that is not drained
    glog.delete();
    wr_cnt = 0;
    af_hits = 0;
    fifo_hold = 1'b1;
    for (int k = 0; k < 20; k++) begin
      push_word(0, k % 16, k == 19);
      sb.push_back(DW'(k % 16));
    end
    repeat (40) @(negedge clk);
    #2;
    chk("t4_writes_full", wr_cnt, 16);
    chk("t4_full", 32'(fifo_full), 1);
    chk("t4_ack_stalled", 32'(ack), 0);
    chk("t4_grant_kept", 32'(grant), 32'(4'b0001));
    chk("t4_words_left", rq[0].size(), 4);
    chk("t4_af_stall_seen", 32'(af_hits > 0), 1);
    fifo_hold = 1'b0;
    wait_done("t4_done", 60);
    chk("t4_writes_total", wr_cnt, 20);
    chk("t4_overflow", ovf, 0);

`ifdef FIFO_ARB_TIMEOUT_EN
    // Timeout: two 8-word streams alternate in 4-word grants
    do_reset();
    for (int k = 0; k < 8; k++) begin
      push_word(0, k, k == 7);
      push_word(1, 8 + k, k == 7);
    end
    for (int k = 0; k < 4; k++) sb.push_back(DW'(k));
    for (int k = 8; k < 12; k++) sb.push_back(DW'(k));
    for (int k = 4; k < 8; k++) sb.push_back(DW'(k));
    for (int k = 12; k < 16; k++) sb.push_back(DW'(k));
    wait_done("t5_done", 100);
    chk("t5_ngrants", glog.size(), 4);
    chk("t5_g0", glog_at(0), 0);
    chk("t5_g1", glog_at(1), 1);
    chk("t5_g2", glog_at(2), 0);
    chk("t5_g3", glog_at(3), 1);
`endif

    // Reset pulsed during the second word of a burst
    glog.delete();
    for (int k = 0; k < 4; k++) push_word(2, 5 + k, k == 3);
    sb.push_back(DW'(5));
    wait_grant("t6_grant2", 2, 20);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("t6_async_wr", 32'(fifo_wr), 0);
    chk("t6_async_grant", 32'(grant), 0);
    chk("t6_async_ack", 32'(ack), 0);
    @(negedge clk); #1;
    chk("t6_next_wr", 32'(fifo_wr), 0);
    chk("t6_next_grant", 32'(grant), 0);
    for (int i = 0; i < NR; i++) rq[i].delete();
    sb.delete();
    @(negedge clk); #1;
    reset = 1'b0;
    glog.delete();
    push_word(0, 3, 1'b1);
    push_word(3, 7, 1'b1);
    sb.push_back(DW'(3));
    sb.push_back(DW'(7));
    wait_done("t6_done", 40);
    chk("t6_ngrants", glog.size(), 2);
    chk("t6_first", glog_at(0), 0);
    chk("t6_second", glog_at(1), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
